// File: rtl/intr_prio_controller.sv
// 8-source fixed-priority interrupt controller with a req/ack/eoi handshake.
// Bit 7 has the highest priority; only one interrupt is in service at a time.
module intr_prio_controller #(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irq_in,
    input  logic       mask_we,
    input  logic [7:0] mask_din,
    output logic [7:0] mask_q,
    output logic [7:0] pending_q,
    output logic [7:0] in_service,
    output logic       int_req,
    input  logic       int_ack,
    output logic [2:0] vector,
    input  logic       eoi
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

    state_e     state_q, state_d;
    logic [7:0] mask_d;
    logic [7:0] pending_d;
    logic [7:0] irqPrev_q;
    logic [7:0] inService_q, inService_d;
    logic [2:0] vector_q, vector_d;

    logic [7:0] rise;
    logic [7:0] eligible;
    logic [7:0] ackClear;
    logic [2:0] topIdx;
    logic       hasEligible;

    assign rise        = irq_in & ~irqPrev_q;
    assign eligible    = pending_q & mask_q;
    assign hasEligible = |eligible;

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        topIdx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (eligible[i]) begin
                topIdx = i[2:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        vector_d    = vector_q;
        inService_d = inService_q;
        ackClear    = 8'h00;
        case (state_q)
            IDLE: begin
                if (hasEligible) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!hasEligible) begin
                    state_d = IDLE;
                end else if (int_ack) begin
                    vector_d    = topIdx;
                    ackClear    = 8'(1) << topIdx;
                    inService_d = 8'(1) << topIdx;
                    state_d     = SERVICE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    inService_d = 8'h00;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new edge on the bit being acknowledged wins over the clear.
    always_comb begin
        if (EDGE_MODE) begin
            pending_d = (pending_q & ~ackClear) | rise;
        end else begin
            pending_d = irq_in;
        end
        mask_d = mask_we ? mask_din : mask_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mask_q      <= 8'h00;
            pending_q   <= 8'h00;
            irqPrev_q   <= 8'h00;
            inService_q <= 8'h00;
            vector_q    <= 3'd0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            pending_q   <= pending_d;
            irqPrev_q   <= irq_in;
            inService_q <= inService_d;
            vector_q    <= vector_d;
        end
    end

    assign int_req    = (state_q == REQ);
    assign in_service = inService_q;
    assign vector     = vector_q;

endmodule
